mem_wb_elastic: RTL

MEM_WB_ELASTIC -- requirements
Module: mem_wb_elastic

---
 rtl/mem_wb_elastic.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/mem_wb_elastic.sv
// MEM/WB elastic stage: two-entry (main + skid) buffer between memory and write-back.
// Optional stall counter compiled in with `define MEM_WB_STALL_CNT_EN.
//
// Ports:
//   i_clk, i_reset (async, active-high), i_flush (sync discard)
//   upstream  : i_valid/o_ready, i_wb, i_mem_to_reg, i_mem_result,
//               i_alu_result, i_addr_wr
//   downstream: o_valid/i_ready, o_wb, o_mem_to_reg, o_mem_result,
//               o_alu_result, o_addr_wr, o_wb_data
//   optional  : o_stall_count (cycles with o_valid && !i_ready, saturating)
module mem_wb_elastic #(
   parameter int BUS_SIZE  = 32,
   parameter int ADDR_SIZE = 5,
   parameter int CNT_SIZE  = 16
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_flush,
   input  logic                 i_valid,
   output logic                 o_ready,
   input  logic                 i_wb,
   input  logic                 i_mem_to_reg,
   input  logic [BUS_SIZE-1:0]  i_mem_result,
   input  logic [BUS_SIZE-1:0]  i_alu_result,
   input  logic [ADDR_SIZE-1:0] i_addr_wr,
   output logic                 o_valid,
   input  logic                 i_ready,
   output logic                 o_wb,
   output logic                 o_mem_to_reg,
   output logic [BUS_SIZE-1:0]  o_mem_result,
   output logic [BUS_SIZE-1:0]  o_alu_result,
   output logic [ADDR_SIZE-1:0] o_addr_wr,
   output logic [BUS_SIZE-1:0]  o_wb_data
`ifdef MEM_WB_STALL_CNT_EN
   ,
   output logic [CNT_SIZE-1:0]  o_stall_count
`endif
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   typedef struct packed {
      logic                 wb;
      logic                 m2r;
      logic [BUS_SIZE-1:0]  mem;
      logic [BUS_SIZE-1:0]  alu;
      logic [ADDR_SIZE-1:0] addr;
   } entry_t;

   state_t state_q, state_d;
   entry_t main_q, main_d;
   entry_t skid_q, skid_d;
   entry_t in_e;
   logic   push;
   logic   pop;

   // Handshake flags come from registered state only; i_ready never
   // reaches o_ready combinationally.
   assign o_ready = (state_q != FULL);
   assign o_valid = (state_q != EMPTY);
   assign push    = i_valid && o_ready;
   assign pop     = o_valid && i_ready;

   assign in_e = '{wb:   i_wb,
                   m2r:  i_mem_to_reg,
                   mem:  i_mem_result,
                   alu:  i_alu_result,
                   addr: i_addr_wr};

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (i_flush) begin
         state_d = EMPTY;
      end else begin
         unique case (state_q)
            EMPTY: begin
               if (push) begin
                  main_d  = in_e;
                  state_d = ONE;
               end
            end
            ONE: begin
               // Simultaneous push/pop refills main directly.
               if (push && pop) begin
                  main_d = in_e;
               end else if (push) begin
                  skid_d  = in_e;
                  state_d = FULL;
               end else if (pop) begin
                  state_d = EMPTY;
               end
            end
            FULL: begin
               if (pop) begin
                  main_d  = skid_q;
                  state_d = ONE;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q <= EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

   // Gate the write enable so an idle stage never requests a write.
   assign o_wb         = main_q.wb && o_valid;
   assign o_mem_to_reg = main_q.m2r;
   assign o_mem_result = main_q.mem;
   assign o_alu_result = main_q.alu;
   assign o_addr_wr    = main_q.addr;
   assign o_wb_data    = main_q.m2r ? main_q.mem : main_q.alu;

`ifdef MEM_WB_STALL_CNT_EN
   logic [CNT_SIZE-1:0] stall_cnt_q, stall_cnt_d;

   // Saturating; flush deliberately leaves the count intact.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (o_valid && !i_ready && !(&stall_cnt_q))
         stall_cnt_d = stall_cnt_q + 1'b1;
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) stall_cnt_q <= '0;
      else         stall_cnt_q <= stall_cnt_d;
   end

   assign o_stall_count = stall_cnt_q;
`endif

endmodule
